// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: clock-enable dividers, button edge detection,
// IDLE/RUN/PAUSE/ADJUST sequencing and registered pulses to the min:sec counter.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SAMPLE_HZ = 100,
    parameter int TICK_HZ   = 1,
    parameter int ADJ_HZ    = 2,
    parameter int BLINK_HZ  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       db_sample,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       count_clr,
    output logic       blink,
    output logic [1:0] mode
);

    localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int RUN_DIV    = CLK_HZ / TICK_HZ;
    localparam int ADJ_DIV    = CLK_HZ / ADJ_HZ;
    localparam int BLINK_DIV  = CLK_HZ / BLINK_HZ;
    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(RUN_DIV);
    localparam int AW = $clog2(ADJ_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ADJ   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic          pause_prev_q, reset_prev_q;
    logic          pause_arm_q, pause_arm_d, reset_arm_q, reset_arm_d;
    logic [SW-1:0] sample_cnt_q, sample_cnt_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [AW-1:0] adj_cnt_q, adj_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          db_sample_q, db_sample_d;
    logic          inc_sec_q, inc_sec_d;
    logic          inc_min_q, inc_min_d;
    logic          count_clr_q, count_clr_d;
    logic          blink_q, blink_d;

    // A press needs a low sample since reset (arm) and a rising edge, so a
    // button still held across an async reset does not fire on release.
    logic pause_press, reset_press;
    assign pause_press = btn_pause & ~pause_prev_q & pause_arm_q;
    assign reset_press = btn_reset & ~reset_prev_q & reset_arm_q;
    assign pause_arm_d = pause_arm_q | ~btn_pause;
    assign reset_arm_d = reset_arm_q | ~btn_reset;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: reset press beats adjust switch beats pause press
    always_comb begin
        state_d = state_q;
        if (reset_press)          state_d = S_IDLE;
        else if (sw_adj)          state_d = S_ADJ;
        else if (state_q == S_ADJ) state_d = S_PAUSE;
        else if (pause_press)     state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end

    // Divider next values and registered pulse/blink outputs
    always_comb begin
        logic run_wrap, adj_wrap, blink_wrap, sample_wrap;
        sample_wrap = (sample_cnt_q == SW'(SAMPLE_DIV - 1));
        run_wrap    = (state_q == S_RUN) && (run_cnt_q == RW'(RUN_DIV - 1));
        adj_wrap    = (state_q == S_ADJ) && (adj_cnt_q == AW'(ADJ_DIV - 1));
        blink_wrap  = (state_q == S_ADJ) && (blink_cnt_q == BW'(BLINK_DIV - 1));

        sample_cnt_d = sample_wrap ? '0 : sample_cnt_q + SW'(1);
        db_sample_d  = sample_wrap;

        // Run divider holds through PAUSE so a resume continues the second
        run_cnt_d = run_cnt_q;
        if (state_q == S_RUN) run_cnt_d = run_wrap ? '0 : run_cnt_q + RW'(1);
        if (state_d == S_IDLE || state_d == S_ADJ) run_cnt_d = '0;

        adj_cnt_d   = '0;
        blink_cnt_d = '0;
        if (state_q == S_ADJ && state_d == S_ADJ) begin
            adj_cnt_d   = adj_wrap ? '0 : adj_cnt_q + AW'(1);
            blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
        end
        blink_d = (state_d == S_ADJ) ? (blink_q ^ blink_wrap) : 1'b0;

        // Clear wins over any coincident increment
        count_clr_d = reset_press;
        inc_sec_d   = ~reset_press & (run_wrap | (adj_wrap & ~sw_sel));
        inc_min_d   = ~reset_press & adj_wrap & sw_sel;
    end

    // Datapath registers: edge detect, dividers, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_prev_q <= 1'b0;
            reset_prev_q <= 1'b0;
            pause_arm_q  <= 1'b0;
            reset_arm_q  <= 1'b0;
            sample_cnt_q <= '0;
            run_cnt_q    <= '0;
            adj_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            db_sample_q  <= 1'b0;
            inc_sec_q    <= 1'b0;
            inc_min_q    <= 1'b0;
            count_clr_q  <= 1'b0;
            blink_q      <= 1'b0;
        end else begin
            pause_prev_q <= btn_pause;
            reset_prev_q <= btn_reset;
            pause_arm_q  <= pause_arm_d;
            reset_arm_q  <= reset_arm_d;
            sample_cnt_q <= sample_cnt_d;
            run_cnt_q    <= run_cnt_d;
            adj_cnt_q    <= adj_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            db_sample_q  <= db_sample_d;
            inc_sec_q    <= inc_sec_d;
            inc_min_q    <= inc_min_d;
            count_clr_q  <= count_clr_d;
            blink_q      <= blink_d;
        end
    end

    assign db_sample = db_sample_q;
    assign inc_sec   = inc_sec_q;
    assign inc_min   = inc_min_q;
    assign count_clr = count_clr_q;
    assign blink     = blink_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: per-cycle comparison against a behavioural model
// plus hand-computed literal checks of the directed scenarios.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ = 1000;
    localparam int SDIV = 10, RDIV = 1000, ADIV = 500, BDIV = 250;

    logic clk = 1'b0;
    logic rst_n, btn_pause, btn_reset, sw_adj, sw_sel;
    logic db_sample, inc_sec, inc_min, count_clr, blink;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;

    // model state
    int m_mode, m_cyc, m_run, m_adj;
    bit m_lp, m_lr;
    // observed DUT activity
    int n_db, n_sec, n_min, n_clr, n_tog;
    logic last_blink;

    stopwatch_ctrl #(
        .CLK_HZ(CLK_HZ), .SAMPLE_HZ(100), .TICK_HZ(1), .ADJ_HZ(2), .BLINK_HZ(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_reset(btn_reset),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .db_sample(db_sample), .inc_sec(inc_sec),
        .inc_min(inc_min), .count_clr(count_clr), .blink(blink), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cyc = 0; m_run = 0; m_adj = 0;
        m_lp = 1'b1; m_lr = 1'b1;   // a press needs a low sample first
    endtask

    task automatic clr_obs();
        n_db = 0; n_sec = 0; n_min = 0; n_clr = 0; n_tog = 0;
    endtask

    // One clock: sample inputs at posedge, step the model, compare, return at negedge
    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            bit bp, br, sa, ss, rn, rp, pp;
            int old, nm, e_db, e_sec, e_min, e_clr, e_blk;
            @(posedge clk);
            bp = btn_pause; br = btn_reset; sa = sw_adj; ss = sw_sel; rn = rst_n;
            #1;
            e_db = 0; e_sec = 0; e_min = 0; e_clr = 0; e_blk = 0;
            if (!rn) begin
                model_reset();
            end else begin
                rp = br && !m_lr;
                pp = bp && !m_lp;
                m_lr = br; m_lp = bp;
                m_cyc++;
                e_db = (m_cyc % SDIV == 0) ? 1 : 0;
                old = m_mode;
                if (old == 1) begin
                    m_run++;
                    if (m_run % RDIV == 0) e_sec = 1;
                end
                if (old == 3) begin
                    m_adj++;
                    if (m_adj % ADIV == 0) begin
                        if (ss) e_min = 1; else e_sec = 1;
                    end
                end
                if (rp)            nm = 0;
                else if (sa)       nm = 3;
                else if (old == 3) nm = 2;
                else if (pp)       nm = (old == 1) ? 2 : 1;
                else               nm = old;
                if (rp) begin e_sec = 0; e_min = 0; e_clr = 1; end
                if (nm == 0 || nm == 3) m_run = 0;
                if (nm != 3) m_adj = 0;
                e_blk = (nm == 3) ? ((m_adj / BDIV) % 2) : 0;
                m_mode = nm;
            end
            chk("mode", int'(mode), m_mode);
            chk("db_sample", int'(db_sample), e_db);
            chk("inc_sec", int'(inc_sec), e_sec);
            chk("inc_min", int'(inc_min), e_min);
            chk("count_clr", int'(count_clr), e_clr);
            chk("blink", int'(blink), e_blk);
            if (db_sample) n_db++;
            if (inc_sec) n_sec++;
            if (inc_min) n_min++;
            if (count_clr) n_clr++;
            if (blink !== last_blink) n_tog++;
            last_blink = blink;
            @(negedge clk);
        end
    endtask

    // Cycles until inc_sec is seen; -1 if the budget expires
    task automatic wait_sec(input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            cyc(1);
            if (inc_sec) begin k = i; break; end
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0; btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
        last_blink = 1'b0;
        model_reset();
        clr_obs();

        // 1: reset and idle
        cyc(3);
        chk("reset_mode", int'(mode), 0);
        chk("reset_outs", int'({db_sample, inc_sec, inc_min, count_clr, blink}), 0);
        rst_n = 1'b1;
        clr_obs();
        cyc(50);
        chk("idle_mode", int'(mode), 0);
        chk("idle_db_count", n_db, 5);
        chk("idle_no_pulses", n_sec + n_min + n_clr, 0);

        // 2: pause press held 30 cycles starts RUN once
        btn_pause = 1'b1;
        cyc(1);
        chk("run_entry_mode", int'(mode), 1);
        cyc(29);
        btn_pause = 1'b0;
        wait_sec(2000, k);
        chk("first_inc_sec", k, 971);
        chk("still_run", int'(mode), 1);
        wait_sec(2000, k);
        chk("second_inc_sec", k, 1000);

        // 3: 600 cycles of RUN, long pause, resume finishes the second
        cyc(599);
        btn_pause = 1'b1;
        cyc(1);
        btn_pause = 1'b0;
        chk("pause_mode", int'(mode), 2);
        clr_obs();
        cyc(5000);
        chk("pause_no_inc", n_sec, 0);
        btn_pause = 1'b1;
        cyc(1);
        btn_pause = 1'b0;
        chk("resume_mode", int'(mode), 1);
        wait_sec(2000, k);
        chk("resume_inc_sec", k, 400);

        // 4: adjust minutes for 1100 cycles
        sw_sel = 1'b1; sw_adj = 1'b1;
        cyc(1);
        chk("adj_mode", int'(mode), 3);
        clr_obs();
        cyc(1099);
        chk("adj_inc_min", n_min, 2);
        chk("adj_no_sec", n_sec, 0);
        chk("adj_blink_toggles", n_tog, 4);
        sw_adj = 1'b0;
        cyc(1);
        chk("adj_exit_mode", int'(mode), 2);
        chk("adj_exit_blink", int'(blink), 0);

        // 5: reset and pause pressed together while running
        btn_pause = 1'b1;
        cyc(1);
        btn_pause = 1'b0;
        cyc(10);
        chk("run_again", int'(mode), 1);
        btn_pause = 1'b1; btn_reset = 1'b1;
        cyc(1);
        chk("clr_mode", int'(mode), 0);
        chk("clr_pulse", int'(count_clr), 1);
        btn_pause = 1'b0; btn_reset = 1'b0;
        cyc(1);
        chk("clr_single", int'(count_clr), 0);
        clr_obs();
        cyc(1100);
        chk("idle_after_clr", int'(mode), 0);
        chk("idle_after_clr_inc", n_sec + n_clr, 0);

        // 5b: reset press inside ADJUST, switch still on re-enters ADJUST
        sw_sel = 1'b0; sw_adj = 1'b1;
        cyc(301);
        chk("adj2_mode", int'(mode), 3);
        chk("adj2_blink", int'(blink), 1);
        btn_reset = 1'b1;
        cyc(1);
        btn_reset = 1'b0;
        chk("adj_rst_mode", int'(mode), 0);
        chk("adj_rst_clr", int'(count_clr), 1);
        chk("adj_rst_blink", int'(blink), 0);
        cyc(1);
        chk("adj_reenter", int'(mode), 3);
        clr_obs();
        cyc(500);
        chk("adj_sec_inc", n_sec, 1);
        sw_adj = 1'b0;
        cyc(1);
        chk("adj2_exit", int'(mode), 2);

        // 6: async reset mid-RUN with pause held through release
        btn_pause = 1'b1;
        cyc(1);
        btn_pause = 1'b0;
        cyc(100);
        chk("run3_mode", int'(mode), 1);
        btn_pause = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_mode", int'(mode), 0);
        chk("async_outs", int'({db_sample, inc_sec, inc_min, count_clr, blink}), 0);
        clr_obs();
        @(negedge clk);
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        chk("held_no_press", int'(mode), 0);
        chk("held_no_pulses", n_sec + n_min + n_clr, 0);
        btn_pause = 1'b0;
        cyc(1);
        btn_pause = 1'b1;
        cyc(1);
        btn_pause = 1'b0;
        chk("press_after_low", int'(mode), 1);
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
